multi_alarm_clock: RTL and testbench
====================================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 The block SHALL take parameter NUM_ALARMS, default 4, meaning the number of independent alarm slots (1..16).
REQ-002 The block SHALL take parameter MODE_12H, default 1, meaning 1 = 12-hour range 01:00..12:59 and 0 = 24-hour range 00:00..23:59.
REQ-003 The block SHALL take parameter SNOOZE_MIN, default 5, meaning the minutes (ticks) before a snoozed alarm re-rings (1..59).
REQ-004 The block SHALL take parameter BLINK_DIV, default 25, meaning the clk cycles per LED blink half-period.
REQ-005 The block SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- tick  in  1  one-cycle pulse; advance time by one minute.
- set_time  in  1  one-cycle pulse; load time_in.
- time_in  in  16  BCD HH:MM.
- alarm_wr  in  1  one-cycle pulse; write one alarm slot.
- alarm_idx  in  clog2(NUM_ALARMS)  slot to write.
- alarm_in  in  16  BCD alarm time.
- alarm_en_in  in  1  slot enable to write.
- ack  in  1  dismiss the ringing alarm.
- snooze  in  1  snooze the ringing alarm.
- time_out  out  16  current BCD time.
- ringing  out  1  alarm active.
- ring_idx  out  clog2(NUM_ALARMS)  slot that is ringing.
- led  out  16  blink pattern.

Function
REQ-006 On tick, time SHALL advance in BCD: minute units 9->0 with carry; minute tens 5->0 with carry into hours; 12h mode 12:59->01:00; 24h mode 23:59->00:00.
REQ-007 set_time SHALL load time_in on the next edge with clamping: minutes >59 -> 59; hours above maximum -> 12 (12h mode) or 23 (24h mode); hour 00 in 12h mode -> 01; any non-BCD nibble -> treated as out of range.
REQ-008 set_time SHALL take priority over a simultaneous tick; that tick is discarded.
REQ-009 alarm_wr SHALL store alarm_in and alarm_en_in into slot alarm_idx, using the same clamping as REQ-007; writes to idx >= NUM_ALARMS SHALL be ignored.
REQ-010 A match SHALL be evaluated only in the cycle after a tick-driven time update, never after set_time; a match is any enabled slot equal to time_out.
REQ-011 When several slots match, the lowest index SHALL win.
REQ-012 The FSM SHALL have exactly three states: IDLE, RINGING and SNOOZED.
- IDLE -> RINGING: on a match; ring_idx is latched.
- RINGING -> IDLE: on ack.
- RINGING -> SNOOZED: on snooze; the snooze counter is loaded with SNOOZE_MIN.
- SNOOZED: the counter decrements on each tick; on reaching 0 -> RINGING with the same ring_idx.
- SNOOZED -> IDLE: on ack.
REQ-013 ack SHALL take priority over a simultaneous snooze.
REQ-014 A new match while in RINGING or SNOOZED SHALL be ignored.
REQ-015 alarm_wr to the slot held in ring_idx while in RINGING or SNOOZED SHALL return the FSM to IDLE.
REQ-016 ringing SHALL be 1 only in RINGING.
REQ-017 led SHALL be 16'hFFFF on entry to RINGING and invert every BLINK_DIV cycles while in RINGING; outside RINGING it SHALL be 16'h0000 and the blink counter SHALL be held at 0.
REQ-018 time_out SHALL be registered and reflect an update one cycle after the tick or set_time edge.

Reset
REQ-019 On rst, the block SHALL set time_out to 12:00 (MODE_12H=1) or 00:00 (MODE_12H=0).
REQ-020 On rst, the block SHALL clear all slot enables, set all slot times to 12:00 (12h mode) or 00:00 (24h mode), set the FSM to IDLE, and set ringing=0, ring_idx=0, led=0 and both counters to 0.
REQ-021 rst SHALL override every other input in the same cycle, including mid-ring and mid-snooze.

Structure
REQ-022 Package multi_alarm_pkg SHALL hold the BCD time typedef (hh_t, hl_t, mh_t, ml_t nibbles), the FSM state enum, the clamp function and the reset-time constants.
REQ-023 Sub-module bcd_time_counter SHALL implement the tick/set/clamp time register for the main counter; alarm storage SHALL remain in the top level.

Verification
REQ-024 The bench SHALL check time wrap in 12h mode: set 12:58, apply 2 ticks -> 12:59 then 01:00; in 24h mode, 23:59 plus one tick -> 00:00.
REQ-025 The bench SHALL check clamping: set_time 16'h1375 (12h) -> 12:59; set_time 16'h0030 (12h) -> 01:30.
REQ-026 The bench SHALL check priority: enable slots 1 and 3 both at 07:00, tick from 06:59 -> ringing=1 and ring_idx=1; the led pattern toggles after 25 cycles.
REQ-027 The bench SHALL check snooze: while ringing at 07:00, snooze, then 4 ticks -> ringing=0; the 5th tick -> ringing=1, ring_idx unchanged; then ack -> IDLE and led=0.
REQ-028 The bench SHALL check simultaneous events: ack and snooze in the same cycle -> IDLE; set_time and tick in the same cycle -> time_in loaded and no advance.
REQ-029 The bench SHALL check reset mid-snooze: rst asserted -> time 12:00, ringing=0, all slots disabled, and no re-ring after SNOOZE_MIN ticks.

Source files
------------

// File: rtl/multi_alarm_pkg.sv
// Shared types and helpers for the multi-alarm clock.
// Holds the BCD time layout, the alarm FSM states and the clamp rule.
package multi_alarm_pkg;

    typedef logic [3:0] hh_t;
    typedef logic [3:0] hl_t;
    typedef logic [3:0] mh_t;
    typedef logic [3:0] ml_t;

    typedef struct packed {
        hh_t hh;
        hl_t hl;
        mh_t mh;
        ml_t ml;
    } bcd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_e;

    localparam bcd_time_t RST_TIME_12H = 16'h1200;
    localparam bcd_time_t RST_TIME_24H = 16'h0000;

    function automatic bcd_time_t rst_time(input bit mode12);
        return mode12 ? RST_TIME_12H : RST_TIME_24H;
    endfunction

    // Force a raw BCD word into the legal range of the clock.
    // Any non-decimal nibble makes that field out of range.
    function automatic bcd_time_t clamp_time(
        input logic [15:0] raw,
        input bit          mode12
    );
        bcd_time_t  t;
        logic [7:0] hv;
        logic       h_ok;
        t = bcd_time_t'(raw);
        if (t.mh > 4'd5 || t.ml > 4'd9) begin
            t.mh = 4'd5;
            t.ml = 4'd9;
        end
        h_ok = (t.hh <= 4'd9) && (t.hl <= 4'd9);
        hv   = {4'd0, t.hh} * 8'd10 + {4'd0, t.hl};
        if (mode12) begin
            if (!h_ok || hv > 8'd12) begin
                t.hh = 4'd1;
                t.hl = 4'd2;
            end else if (hv == 8'd0) begin
                t.hh = 4'd0;
                t.hl = 4'd1;
            end
        end else if (!h_ok || hv > 8'd23) begin
            t.hh = 4'd2;
            t.hl = 4'd3;
        end
        return t;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Main BCD HH:MM register: minute ticks, clamped loads, 12h/24h wrap.
// Ports: clk, rst, tick, set_time, time_in -> time_out, tick_upd.
module bcd_time_counter
    import multi_alarm_pkg::*;
#(
    parameter bit MODE_12H = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        set_time,
    input  logic [15:0] time_in,
    output logic [15:0] time_out,
    output logic        tick_upd
);

    bcd_time_t cur;

    function automatic bcd_time_t next_minute(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.ml != 4'd9) begin
            n.ml = t.ml + 4'd1;
        end else begin
            n.ml = 4'd0;
            if (t.mh != 4'd5) begin
                n.mh = t.mh + 4'd1;
            end else begin
                n.mh = 4'd0;
                if (MODE_12H && t.hh == 4'd1 && t.hl == 4'd2) begin
                    n.hh = 4'd0;
                    n.hl = 4'd1;
                end else if (!MODE_12H && t.hh == 4'd2 && t.hl == 4'd3) begin
                    n.hh = 4'd0;
                    n.hl = 4'd0;
                end else if (t.hl == 4'd9) begin
                    n.hl = 4'd0;
                    n.hh = t.hh + 4'd1;
                end else begin
                    n.hl = t.hl + 4'd1;
                end
            end
        end
        return n;
    endfunction

    // tick_upd marks the cycle in which a tick-advanced time is visible,
    // which is the only cycle alarms get compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= rst_time(MODE_12H);
            tick_upd <= 1'b0;
        end else begin
            tick_upd <= 1'b0;
            if (set_time) begin
                cur <= clamp_time(time_in, MODE_12H);
            end else if (tick) begin
                cur      <= next_minute(cur);
                tick_upd <= 1'b1;
            end
        end
    end

    assign time_out = cur;

endmodule

// File: rtl/multi_alarm_clock.sv
// Multi-slot alarm clock: time counter, alarm slots, ring/snooze FSM, LED blink.
// Ports: clk, rst, tick, set_time/time_in, alarm_wr/idx/in/en_in, ack, snooze
//        -> time_out, ringing, ring_idx, led.
module multi_alarm_clock
    import multi_alarm_pkg::*;
#(
    parameter  int NUM_ALARMS = 4,
    parameter  int MODE_12H   = 1,
    parameter  int SNOOZE_MIN = 5,
    parameter  int BLINK_DIV  = 25,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          set_time,
    input  logic [15:0]   time_in,
    input  logic          alarm_wr,
    input  logic [IW-1:0] alarm_idx,
    input  logic [15:0]   alarm_in,
    input  logic          alarm_en_in,
    input  logic          ack,
    input  logic          snooze,
    output logic [15:0]   time_out,
    output logic          ringing,
    output logic [IW-1:0] ring_idx,
    output logic [15:0]   led
);

    localparam bit M12 = (MODE_12H != 0);
    localparam int BW  = $clog2(BLINK_DIV + 1);

    logic                  tick_upd;
    bcd_time_t             slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slot_en;
    logic                  idx_ok;
    logic                  hit;
    logic [IW-1:0]         hit_idx;
    logic                  kill;
    logic                  tick_eff;
    alarm_state_e          state;
    logic [BW-1:0]         blink_cnt;
    logic [5:0]            snz_cnt;

    bcd_time_counter #(
        .MODE_12H (M12)
    ) u_time (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .set_time (set_time),
        .time_in  (time_in),
        .time_out (time_out),
        .tick_upd (tick_upd)
    );

    assign idx_ok   = (int'(alarm_idx) < NUM_ALARMS);
    assign tick_eff = tick && !set_time;
    assign kill     = alarm_wr && idx_ok && (alarm_idx == ring_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_time[i] <= rst_time(M12);
            end
            slot_en <= '0;
        end else if (alarm_wr && idx_ok) begin
            slot_time[alarm_idx] <= clamp_time(alarm_in, M12);
            slot_en[alarm_idx]   <= alarm_en_in;
        end
    end

    // Scan downwards so the lowest matching slot is the last writer.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_time[i] == bcd_time_t'(time_out))) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ringing   <= 1'b0;
            ring_idx  <= '0;
            led       <= 16'h0000;
            blink_cnt <= '0;
            snz_cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    led       <= 16'h0000;
                    blink_cnt <= '0;
                    snz_cnt   <= '0;
                    if (tick_upd && hit) begin
                        state    <= ST_RINGING;
                        ringing  <= 1'b1;
                        ring_idx <= hit_idx;
                        led      <= 16'hFFFF;
                    end
                end
                ST_RINGING: begin
                    if (ack || kill) begin
                        state     <= ST_IDLE;
                        ringing   <= 1'b0;
                        led       <= 16'h0000;
                        blink_cnt <= '0;
                    end else if (snooze) begin
                        state     <= ST_SNOOZED;
                        ringing   <= 1'b0;
                        led       <= 16'h0000;
                        blink_cnt <= '0;
                        snz_cnt   <= 6'(SNOOZE_MIN);
                    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                        blink_cnt <= '0;
                        led       <= ~led;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                ST_SNOOZED: begin
                    if (ack || kill) begin
                        state   <= ST_IDLE;
                        snz_cnt <= '0;
                    end else if (tick_eff) begin
                        if (snz_cnt == 6'd1) begin
                            state     <= ST_RINGING;
                            ringing   <= 1'b1;
                            led       <= 16'hFFFF;
                            blink_cnt <= '0;
                            snz_cnt   <= '0;
                        end else begin
                            snz_cnt <= snz_cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ringing <= 1'b0;
                    led     <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: minute-level model plus directed vectors.
// A 24h instance shares the stimulus for the midnight wrap.
module tb_multi_alarm_clock;

    localparam int NA   = 4;
    localparam int SNZ  = 5;
    localparam int BDIV = 25;

    logic        clk = 1'b0;
    logic        rst, tick, set_time, alarm_wr, alarm_en_in, ack, snooze;
    logic [1:0]  alarm_idx;
    logic [15:0] time_in, alarm_in;
    logic [15:0] time_out, led, time_out24, led24;
    logic        ringing, ringing24;
    logic [1:0]  ring_idx, ring_idx24;

    int checks = 0;
    int errors = 0;

    int m_h, m_m;
    int s_min [NA];
    bit s_en [NA];
    int m_st;
    int m_idx, m_left, m_age;
    bit m_pend;

    always #5 clk = ~clk;

    multi_alarm_clock #(
        .NUM_ALARMS (NA),
        .MODE_12H   (1),
        .SNOOZE_MIN (SNZ),
        .BLINK_DIV  (BDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .set_time    (set_time),
        .time_in     (time_in),
        .alarm_wr    (alarm_wr),
        .alarm_idx   (alarm_idx),
        .alarm_in    (alarm_in),
        .alarm_en_in (alarm_en_in),
        .ack         (ack),
        .snooze      (snooze),
        .time_out    (time_out),
        .ringing     (ringing),
        .ring_idx    (ring_idx),
        .led         (led)
    );

    multi_alarm_clock #(
        .NUM_ALARMS (NA),
        .MODE_12H   (0),
        .SNOOZE_MIN (SNZ),
        .BLINK_DIV  (BDIV)
    ) dut24 (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .set_time    (set_time),
        .time_in     (time_in),
        .alarm_wr    (alarm_wr),
        .alarm_idx   (alarm_idx),
        .alarm_in    (alarm_in),
        .alarm_en_in (alarm_en_in),
        .ack         (ack),
        .snooze      (snooze),
        .time_out    (time_out24),
        .ringing     (ringing24),
        .ring_idx    (ring_idx24),
        .led         (led24)
    );

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // 12h clamp rule in plain decimal arithmetic.
    task automatic decode(input logic [15:0] t, output int h, output int m);
        int a, b, c, d;
        a = int'(t[15:12]);
        b = int'(t[11:8]);
        c = int'(t[7:4]);
        d = int'(t[3:0]);
        if (c > 9 || d > 9 || c * 10 + d > 59) m = 59;
        else m = c * 10 + d;
        if (a > 9 || b > 9 || a * 10 + b > 12) h = 12;
        else if (a * 10 + b == 0) h = 1;
        else h = a * 10 + b;
    endtask

    function automatic logic [15:0] enc(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic model_step();
        int  nh, nm, idx;
        bit  found, kill, tk;
        idx = int'(alarm_idx);
        if (rst) begin
            m_h = 12;
            m_m = 0;
            for (int i = 0; i < NA; i++) begin
                s_min[i] = 720;
                s_en[i]  = 1'b0;
            end
            m_st   = 0;
            m_idx  = 0;
            m_left = 0;
            m_age  = 0;
            m_pend = 1'b0;
        end else begin
            kill  = alarm_wr && idx < NA && idx == m_idx;
            tk    = tick && !set_time;
            found = 1'b0;
            case (m_st)
                0: if (m_pend) begin
                    for (int i = 0; i < NA; i++) begin
                        if (!found && s_en[i] && s_min[i] == m_h * 60 + m_m) begin
                            found = 1'b1;
                            m_st  = 1;
                            m_idx = i;
                            m_age = 0;
                        end
                    end
                end
                1: begin
                    if (ack || kill) m_st = 0;
                    else if (snooze) begin
                        m_st   = 2;
                        m_left = SNZ;
                    end else m_age++;
                end
                default: begin
                    if (ack || kill) m_st = 0;
                    else if (tk) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_st  = 1;
                            m_age = 0;
                        end
                    end
                end
            endcase
            if (alarm_wr && idx < NA) begin
                decode(alarm_in, nh, nm);
                s_min[idx] = nh * 60 + nm;
                s_en[idx]  = alarm_en_in;
            end
            m_pend = 1'b0;
            if (set_time) begin
                decode(time_in, m_h, m_m);
            end else if (tick) begin
                m_m++;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h++;
                    if (m_h == 13) m_h = 1;
                end
                m_pend = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("time_out", time_out, enc(m_h, m_m));
        chk("ringing", {15'd0, ringing}, {15'd0, (m_st == 1)});
        chk("ring_idx", {14'd0, ring_idx}, 16'(m_idx));
        chk("led", led,
            (m_st == 1 && (m_age / BDIV) % 2 == 0) ? 16'hFFFF : 16'h0000);
    end

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_t(input logic [15:0] t);
        set_time = 1'b1;
        time_in  = t;
        @(negedge clk);
        set_time = 1'b0;
    endtask

    task automatic wr(input logic [1:0] i, input logic [15:0] t, input logic en);
        alarm_wr    = 1'b1;
        alarm_idx   = i;
        alarm_in    = t;
        alarm_en_in = en;
        @(negedge clk);
        alarm_wr    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        set_time = 1'b0;
        time_in = '0;
        alarm_wr = 1'b0;
        alarm_idx = '0;
        alarm_in = '0;
        alarm_en_in = 1'b0;
        ack = 1'b0;
        snooze = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_time12", time_out, 16'h1200);
        chk("rst_time24", time_out24, 16'h0000);
        chk("rst_led", led, 16'h0000);

        set_t(16'h1258);
        pulse_tick();
        chk("wrap_1259", time_out, 16'h1259);
        pulse_tick();
        chk("wrap_0100", time_out, 16'h0100);
        chk("t24_1300", time_out24, 16'h1300);

        set_t(16'h2359);
        chk("t24_2359", time_out24, 16'h2359);
        chk("clamp_2359_12h", time_out, 16'h1259);
        pulse_tick();
        chk("t24_wrap", time_out24, 16'h0000);

        set_t(16'h1375);
        chk("clamp_1375", time_out, 16'h1259);
        set_t(16'h0030);
        chk("clamp_0030", time_out, 16'h0130);
        set_t(16'h1A3F);
        chk("clamp_nonbcd", time_out, 16'h1259);

        wr(2'd1, 16'h0700, 1'b1);
        wr(2'd3, 16'h0700, 1'b1);
        set_t(16'h0659);
        pulse_tick();
        chk("prio_ring", {15'd0, ringing}, 16'd1);
        chk("prio_idx", {14'd0, ring_idx}, 16'd1);
        repeat (24) @(negedge clk);
        chk("blink_on", led, 16'hFFFF);
        @(negedge clk);
        chk("blink_off", led, 16'h0000);

        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        chk("snz_quiet", {15'd0, ringing}, 16'd0);
        repeat (4) pulse_tick();
        chk("snz_4ticks", {15'd0, ringing}, 16'd0);
        pulse_tick();
        chk("snz_rering", {15'd0, ringing}, 16'd1);
        chk("snz_idx", {14'd0, ring_idx}, 16'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_ring", {15'd0, ringing}, 16'd0);
        chk("ack_led", led, 16'h0000);

        wr(2'd0, 16'h0706, 1'b1);
        pulse_tick();
        chk("slot0_idx", {14'd0, ring_idx}, 16'd0);
        ack = 1'b1;
        snooze = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        snooze = 1'b0;
        chk("ack_snz", {15'd0, ringing}, 16'd0);
        repeat (5) pulse_tick();
        chk("ack_snz_norering", {15'd0, ringing}, 16'd0);
        set_time = 1'b1;
        tick = 1'b1;
        time_in = 16'h0930;
        @(negedge clk);
        set_time = 1'b0;
        tick = 1'b0;
        chk("set_over_tick", time_out, 16'h0930);

        wr(2'd2, 16'h0931, 1'b1);
        pulse_tick();
        chk("slot2_idx", {14'd0, ring_idx}, 16'd2);
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        repeat (2) pulse_tick();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midsnz_time", time_out, 16'h1200);
        chk("midsnz_ring", {15'd0, ringing}, 16'd0);
        chk("midsnz_led", led, 16'h0000);
        set_t(16'h0659);
        pulse_tick();
        chk("slots_cleared", {15'd0, ringing}, 16'd0);
        repeat (SNZ) pulse_tick();
        chk("no_rering", {15'd0, ringing}, 16'd0);

        wr(2'd1, 16'h1203, 1'b1);
        set_t(16'h1202);
        pulse_tick();
        chk("kill_pre", {15'd0, ringing}, 16'd1);
        wr(2'd1, 16'h1203, 1'b1);
        chk("kill_wr", {15'd0, ringing}, 16'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
